// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requester-side controller for a combinational add/sub/or/and ALU.
// Accepts one R-type request at a time, drives the ALU from registers for
// EXEC_CYCLES edges, captures the result with zero/overflow/illegal flags and
// holds it until the consumer takes it.
module alu_issue_ctrl #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  // Counter reload: capture happens on the edge where cnt reaches 0, so
  // loading EXEC_CYCLES-1 gives exactly EXEC_CYCLES edges from accept.
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  state_t           state_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, result_q;
  logic [1:0]       alu_op_q;
  logic [3:0]       cnt_q;
  logic             req_ready_q, rsp_valid_q, ovf_q, illegal_q;

  logic [1:0]       dec_op_d;
  logic             dec_legal_d;
  logic             ovf_d;

  // Decode funct; all six bits are compared, anything else is illegal.
  always_comb begin
    dec_op_d    = OP_ADD;
    dec_legal_d = 1'b1;
    case (funct)
      6'h20:   dec_op_d = OP_ADD;
      6'h22:   dec_op_d = OP_SUB;
      6'h25:   dec_op_d = OP_OR;
      6'h24:   dec_op_d = OP_AND;
      default: dec_legal_d = 1'b0;
    endcase
  end

  // Signed overflow from operand/result sign bits; logical ops never overflow.
  always_comb begin
    ovf_d = 1'b0;
    case (alu_op_q)
      OP_ADD: ovf_d = (alu_a_q[WIDTH-1] == alu_b_q[WIDTH-1]) &&
                      (alu_y[WIDTH-1]   != alu_a_q[WIDTH-1]);
      OP_SUB: ovf_d = (alu_a_q[WIDTH-1] != alu_b_q[WIDTH-1]) &&
                      (alu_y[WIDTH-1]   != alu_a_q[WIDTH-1]);
      default: ovf_d = 1'b0;
    endcase
  end

  // Issue FSM: IDLE accepts, EXEC holds ALU inputs and counts, DONE presents result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_ADD;
      cnt_q       <= '0;
      result_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (dec_legal_d) begin
              alu_a_q  <= opa;
              alu_b_q  <= opb;
              alu_op_q <= dec_op_d;
              cnt_q    <= CNT_LOAD;
              state_q  <= S_EXEC;
            end else begin
              // Illegal ops skip the ALU entirely; previous ALU inputs stay put.
              result_q    <= '0;
              illegal_q   <= 1'b1;
              ovf_q       <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            result_q    <= alu_y;
            ovf_q       <= ovf_d;
            illegal_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign overflow  = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: one instance with EXEC_CYCLES=1 driven through a
// scoreboard, one with EXEC_CYCLES=4 for multi-cycle latency and mid-op reset.
module tb_alu_issue_ctrl;
  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance with EXEC_CYCLES=1
  logic         rv1, rr1, sv1, sr1, z1, ov1, il1;
  logic [5:0]   f1;
  logic [W-1:0] a1, b1, aa1, ab1, y1, res1;
  logic [1:0]   op1;
  // instance with EXEC_CYCLES=4
  logic         rv4, rr4, sv4, sr4, z4, ov4, il4;
  logic [5:0]   f4;
  logic [W-1:0] a4, b4, aa4, ab4, y4, res4;
  logic [1:0]   op4;

  alu_issue_ctrl #(.WIDTH(W), .EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .funct(f1),
    .opa(a1), .opb(b1), .alu_a(aa1), .alu_b(ab1), .alu_op(op1), .alu_y(y1),
    .rsp_valid(sv1), .rsp_ready(sr1), .result(res1), .zero(z1),
    .overflow(ov1), .illegal(il1));

  alu_issue_ctrl #(.WIDTH(W), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(rr4), .funct(f4),
    .opa(a4), .opb(b4), .alu_a(aa4), .alu_b(ab4), .alu_op(op4), .alu_y(y4),
    .rsp_valid(sv4), .rsp_ready(sr4), .result(res4), .zero(z4),
    .overflow(ov4), .illegal(il4));

  // the combinational ALUs the controllers drive
  always_comb begin
    case (op1)
      2'b00:   y1 = aa1 + ab1;
      2'b01:   y1 = aa1 - ab1;
      2'b10:   y1 = aa1 | ab1;
      default: y1 = aa1 & ab1;
    endcase
  end
  always_comb begin
    case (op4)
      2'b00:   y4 = aa4 + ab4;
      2'b01:   y4 = aa4 - ab4;
      2'b10:   y4 = aa4 | ab4;
      default: y4 = aa4 & ab4;
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         z, ov, il;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  // reference result computed with wide signed arithmetic
  function automatic exp_t ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sbv, r;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    e.il = 1'b0; e.ov = 1'b0; e.res = '0;
    case (f)
      6'h20: begin r = sa + sbv; e.res = a + b; e.ov = (r > MAXS) || (r < MINS); end
      6'h22: begin r = sa - sbv; e.res = a - b; e.ov = (r > MAXS) || (r < MINS); end
      6'h25: e.res = a | b;
      6'h24: e.res = a & b;
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic logic [1:0] exp_op(input logic [5:0] f);
    case (f)
      6'h22:   return 2'b01;
      6'h25:   return 2'b10;
      6'h24:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // scoreboard monitor: compare when the response handshake is about to occur
  always @(negedge clk) begin
    if (sv1 && sr1) begin
      if (sb.size() == 0) chk("sb_unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", res1, e.res);
        chk("zero", z1, e.z);
        chk("overflow", ov1, e.ov);
        chk("illegal", il1, e.il);
      end
    end
  end

  // one transaction on dut1; 'hold' cycles of response backpressure with a
  // competing request that must be ignored
  task automatic run1(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    int   lat;
    e = ref_op(f, a, b);
    chk("req_ready_idle", rr1, 1);
    rv1 = 1'b1; f1 = f; a1 = a; b1 = b;
    @(posedge clk); #1;
    rv1 = 1'b0;
    sb.push_back(e);
    chk("req_ready_busy", rr1, 0);
    if (!e.il) begin
      chk("alu_op", op1, exp_op(f));
      chk("alu_a", aa1, a);
      chk("alu_b", ab1, b);
    end
    lat = 0;
    while (!sv1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, e.il ? 0 : 1);
    for (int i = 0; i < hold; i++) begin
      rv1 = 1'b1; f1 = 6'h20; a1 = 32'd100; b1 = 32'd200;
      @(posedge clk); #1;
      chk("hold_valid", sv1, 1);
      chk("hold_result", res1, e.res);
      chk("hold_illegal", il1, e.il);
      chk("hold_req_ready", rr1, 0);
    end
    rv1 = 1'b0;
    sr1 = 1'b1;
    @(posedge clk); #1;
    sr1 = 1'b0;
    chk("rsp_valid_drop", sv1, 0);
    chk("req_ready_back", rr1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst = 1'b1;
    rv1 = 0; f1 = 0; a1 = 0; b1 = 0; sr1 = 0;
    rv4 = 0; f4 = 0; a4 = 0; b4 = 0; sr4 = 0;
    #2;
    chk("rst_rsp_valid", sv1, 0);
    chk("rst_result", res1, 0);
    chk("rst_zero", z1, 1);
    chk("rst_alu_op", op1, 0);
    chk("rst_alu_a", aa1, 0);
    chk("rst_overflow", ov1, 0);
    chk("rst_illegal", il1, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_req_ready", rr1, 1);
    @(posedge clk); #1;

    // add, sub-to-zero, sub overflow, add overflow, add wrap, or, and
    run1(6'h20, 32'd5, 32'd7, 0);
    run1(6'h22, 32'd9, 32'd9, 0);
    run1(6'h22, 32'h8000_0000, 32'd1, 0);
    run1(6'h20, 32'h7FFF_FFFF, 32'd1, 0);
    run1(6'h20, 32'hFFFF_FFFF, 32'd1, 0);
    run1(6'h25, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    run1(6'h24, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    // illegal codes, one with backpressure
    run1(6'h00, 32'd3, 32'd4, 5);
    run1(6'h21, 32'd3, 32'd4, 0);
    // a few random ops with random backpressure
    for (int i = 0; i < 6; i++) begin
      logic [5:0] ff;
      case ($urandom_range(0, 3))
        0: ff = 6'h20; 1: ff = 6'h22; 2: ff = 6'h25; default: ff = 6'h24;
      endcase
      run1(ff, $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    // reset in the middle of a 4-cycle op
    chk("d4_req_ready", rr4, 1);
    rv4 = 1'b1; f4 = 6'h20; a4 = 32'd3; b4 = 32'd4;
    @(posedge clk); #1;
    rv4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", sv4, 0);
    chk("midrst_alu_a", aa4, 0);
    chk("midrst_alu_b", ab4, 0);
    chk("midrst_result", res4, 0);
    chk("midrst_zero", z4, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", sv4, 0);
    end
    chk("d4_req_ready_after", rr4, 1);
    rv4 = 1'b1; f4 = 6'h20; a4 = 32'd1; b4 = 32'd1;
    @(posedge clk); #1;
    rv4 = 1'b0;
    lat = 0;
    while (!sv4 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("d4_latency", lat, 4);
    chk("d4_result", res4, 2);
    chk("d4_overflow", ov4, 0);
    chk("d4_illegal", il4, 0);
    sr4 = 1'b1;
    @(posedge clk); #1;
    sr4 = 1'b0;
    chk("d4_rsp_drop", sv4, 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
